// File: rtl/sdram_burst_scheduler.sv
// Burst scheduler for the single SDRAM command controller: arbitrates refresh, write FIFO and read FIFO,
// issues one burst at a time and owns the running write/read frame addresses.
module sdram_burst_scheduler #(
    parameter int ADDR_W      = 22,
    parameter int LEN_W       = 9,
    parameter int USED_W      = 10,
    parameter int RD_LOW_MARK = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sdram_init_done,
    input  logic [USED_W-1:0] wr_fifo_used,
    input  logic [USED_W-1:0] rd_fifo_used,
    input  logic              rd_enable,
    input  logic [LEN_W-1:0]  wr_length,
    input  logic [LEN_W-1:0]  rd_length,
    input  logic [ADDR_W-1:0] wr_base,
    input  logic [ADDR_W-1:0] wr_max,
    input  logic [ADDR_W-1:0] rd_base,
    input  logic [ADDR_W-1:0] rd_max,
    input  logic              wr_load,
    input  logic              rd_load,
    input  logic              ref_req,
    input  logic              cmd_ack,
    input  logic              cmd_done,
    output logic              cmd_req,
    output logic [1:0]        cmd_type,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [LEN_W-1:0]  cmd_len,
    output logic              frame_write_done,
    output logic              frame_read_done,
    output logic              busy
);

    localparam int CMP_W = (USED_W > LEN_W) ? USED_W : LEN_W;
    localparam logic [USED_W-1:0] RD_MARK = USED_W'(RD_LOW_MARK);

    localparam logic [1:0] CMD_NONE    = 2'b00;
    localparam logic [1:0] CMD_WRITE   = 2'b01;
    localparam logic [1:0] CMD_READ    = 2'b10;
    localparam logic [1:0] CMD_REFRESH = 2'b11;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [1:0]        grant_type;
    logic              last_grant_rd;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_load_pend;
    logic              rd_load_pend;
    logic              ref_elig;
    logic              wr_elig;
    logic              rd_elig;
    logic              cmd_finish;
    logic              wr_locked;
    logic              rd_locked;
    logic [ADDR_W:0]   wr_next;
    logic [ADDR_W:0]   rd_next;
    logic              wr_wrap;
    logic              rd_wrap;

    assign ref_elig = sdram_init_done & ref_req;
    assign wr_elig  = sdram_init_done & (CMP_W'(wr_fifo_used) >= CMP_W'(wr_length));
    assign rd_elig  = sdram_init_done & rd_enable & (rd_fifo_used <= RD_MARK);

    // A done only counts once the command was acked, either earlier or in the same cycle.
    assign cmd_finish = ((state == ISSUE) && cmd_ack && cmd_done) ||
                        ((state == WAIT_DONE) && cmd_done);

    // Once the controller has taken the address, a load must wait for the burst to finish.
    assign wr_locked = (cmd_type == CMD_WRITE) && (((state == ISSUE) && cmd_ack) || (state == WAIT_DONE));
    assign rd_locked = (cmd_type == CMD_READ)  && (((state == ISSUE) && cmd_ack) || (state == WAIT_DONE));

    assign wr_next = {1'b0, wr_addr} + (ADDR_W+1)'(wr_length);
    assign rd_next = {1'b0, rd_addr} + (ADDR_W+1)'(rd_length);
    assign wr_wrap = wr_next >= {1'b0, wr_max};
    assign rd_wrap = rd_next >= {1'b0, rd_max};

    assign cmd_req = (state == ISSUE);
    assign busy    = (state == ISSUE) || (state == WAIT_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_type = CMD_NONE;
        case (state)
            IDLE: begin
                if (ref_elig) begin
                    grant_type = CMD_REFRESH;
                end else if (wr_elig && (!rd_elig || last_grant_rd)) begin
                    grant_type = CMD_WRITE;
                end else if (rd_elig) begin
                    grant_type = CMD_READ;
                end
                if (grant_type != CMD_NONE) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_ack) begin
                    state_next = cmd_done ? IDLE : WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (cmd_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Command fields are captured on the grant edge and cleared when the command completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_type      <= CMD_NONE;
            cmd_addr      <= '0;
            cmd_len       <= '0;
            last_grant_rd <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    cmd_type <= grant_type;
                    case (grant_type)
                        CMD_WRITE: begin
                            cmd_addr      <= wr_load ? wr_base : wr_addr;
                            cmd_len       <= wr_length;
                            last_grant_rd <= 1'b0;
                        end
                        CMD_READ: begin
                            cmd_addr      <= rd_load ? rd_base : rd_addr;
                            cmd_len       <= rd_length;
                            last_grant_rd <= 1'b1;
                        end
                        default: begin
                            cmd_addr <= '0;
                            cmd_len  <= '0;
                        end
                    endcase
                end
                ISSUE: begin
                    if (!cmd_ack) begin
                        if ((cmd_type == CMD_WRITE) && wr_load) begin
                            cmd_addr <= wr_base;
                        end else if ((cmd_type == CMD_READ) && rd_load) begin
                            cmd_addr <= rd_base;
                        end
                    end else if (cmd_done) begin
                        cmd_type <= CMD_NONE;
                        cmd_addr <= '0;
                        cmd_len  <= '0;
                    end
                end
                WAIT_DONE: begin
                    if (cmd_done) begin
                        cmd_type <= CMD_NONE;
                        cmd_addr <= '0;
                        cmd_len  <= '0;
                    end
                end
                default: begin
                    cmd_type <= CMD_NONE;
                    cmd_addr <= '0;
                    cmd_len  <= '0;
                end
            endcase
        end
    end

    // Write frame address: a completed burst advances or wraps it; a load wins over the increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr          <= '0;
            wr_load_pend     <= 1'b0;
            frame_write_done <= 1'b0;
        end else begin
            frame_write_done <= 1'b0;
            if (cmd_finish && (cmd_type == CMD_WRITE)) begin
                wr_addr          <= (wr_wrap || wr_load || wr_load_pend) ? wr_base : wr_next[ADDR_W-1:0];
                frame_write_done <= wr_wrap;
                wr_load_pend     <= 1'b0;
            end else if (wr_load) begin
                if (wr_locked) begin
                    wr_load_pend <= 1'b1;
                end else begin
                    wr_addr <= wr_base;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr         <= '0;
            rd_load_pend    <= 1'b0;
            frame_read_done <= 1'b0;
        end else begin
            frame_read_done <= 1'b0;
            if (cmd_finish && (cmd_type == CMD_READ)) begin
                rd_addr         <= (rd_wrap || rd_load || rd_load_pend) ? rd_base : rd_next[ADDR_W-1:0];
                frame_read_done <= rd_wrap;
                rd_load_pend    <= 1'b0;
            end else if (rd_load) begin
                if (rd_locked) begin
                    rd_load_pend <= 1'b1;
                end else begin
                    rd_addr <= rd_base;
                end
            end
        end
    end

endmodule

// File: tb/tb_sdram_burst_scheduler.sv
// Self-checking bench for sdram_burst_scheduler: a transaction-level model checked every cycle,
// plus directed scenarios with hand-computed command sequences and timings.
module tb_sdram_burst_scheduler;

    localparam int RD_MARK_TB = 256;

    logic        clk;
    logic        rst;
    logic        sdram_init_done;
    logic [9:0]  wr_fifo_used;
    logic [9:0]  rd_fifo_used;
    logic        rd_enable;
    logic [8:0]  wr_length;
    logic [8:0]  rd_length;
    logic [21:0] wr_base;
    logic [21:0] wr_max;
    logic [21:0] rd_base;
    logic [21:0] rd_max;
    logic        wr_load;
    logic        rd_load;
    logic        ref_req;
    logic        cmd_ack;
    logic        cmd_done;
    logic        cmd_req;
    logic [1:0]  cmd_type;
    logic [21:0] cmd_addr;
    logic [8:0]  cmd_len;
    logic        frame_write_done;
    logic        frame_read_done;
    logic        busy;

    logic resp_en, resp_ack, resp_done, man_ack, man_done;
    int   done_dly, rphase, rcnt;

    int compared, mismatched;
    bit chk_en;
    int issue_count, fwd_count, frd_count;
    bit prev_req;
    longint q_type[$];
    longint q_addr[$];

    // Model state: a command is either absent, offered (not yet acked) or accepted.
    bit     m_busy, m_acked, m_last_rd, m_wr_pend, m_rd_pend, m_fwd, m_frd;
    bit     m_done_now, m_wr_ok, m_rd_ok;
    longint m_type, m_addr, m_len, m_wr_addr, m_rd_addr, m_nxt;

    assign cmd_ack  = resp_ack | man_ack;
    assign cmd_done = resp_done | man_done;

    sdram_burst_scheduler dut (
        .clk(clk), .rst(rst), .sdram_init_done(sdram_init_done),
        .wr_fifo_used(wr_fifo_used), .rd_fifo_used(rd_fifo_used), .rd_enable(rd_enable),
        .wr_length(wr_length), .rd_length(rd_length),
        .wr_base(wr_base), .wr_max(wr_max), .rd_base(rd_base), .rd_max(rd_max),
        .wr_load(wr_load), .rd_load(rd_load), .ref_req(ref_req),
        .cmd_ack(cmd_ack), .cmd_done(cmd_done),
        .cmd_req(cmd_req), .cmd_type(cmd_type), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .frame_write_done(frame_write_done), .frame_read_done(frame_read_done), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input bit init, input int wr_used, input int rd_used, input bit rd_en,
                                 input int wr_len, input int rd_len, input bit refr);
        sdram_init_done = init;
        wr_fifo_used    = 10'(wr_used);
        rd_fifo_used    = 10'(rd_used);
        rd_enable       = rd_en;
        wr_length       = 9'(wr_len);
        rd_length       = 9'(rd_len);
        ref_req         = refr;
    endtask

    task automatic do_reset();
        resp_en  = 1'b0;
        man_ack  = 1'b0;
        man_done = 1'b0;
        wr_load  = 1'b0;
        rd_load  = 1'b0;
        rst      = 1'b1;
        tick();
        tick();
        chk_en      = 1'b1;
        issue_count = 0;
        fwd_count   = 0;
        frd_count   = 0;
        prev_req    = 1'b0;
        q_type.delete();
        q_addr.delete();
        rst = 1'b0;
    endtask

    task automatic wait_issues(input string name, input int n, input int budget);
        int k = 0;
        while (issue_count < n && k < budget) begin
            tick();
            k++;
        end
        checkOutput(name, longint'(issue_count >= n), 1);
    endtask

    task automatic wait_accepted(input string name);
        int k = 0;
        while (!(busy && !cmd_req) && k < 40) begin
            tick();
            k++;
        end
        checkOutput(name, longint'(busy && !cmd_req), 1);
    endtask

    function automatic longint get_type(input int i);
        return (i < q_type.size()) ? q_type[i] : -1;
    endfunction

    function automatic longint get_addr(input int i);
        return (i < q_addr.size()) ? q_addr[i] : -1;
    endfunction

    // Controller stand-in: acks as soon as it sees a request, signals done done_dly cycles later.
    always @(negedge clk) begin
        if (!resp_en) begin
            resp_ack  = 1'b0;
            resp_done = 1'b0;
            rphase    = 0;
        end else begin
            case (rphase)
                0: begin
                    resp_ack  = 1'b0;
                    resp_done = 1'b0;
                    if (cmd_req) begin
                        resp_ack = 1'b1;
                        if (done_dly == 0) begin
                            resp_done = 1'b1;
                            rphase    = 3;
                        end else begin
                            rcnt   = done_dly;
                            rphase = 2;
                        end
                    end
                end
                2: begin
                    resp_ack = 1'b0;
                    rcnt--;
                    if (rcnt == 0) begin
                        resp_done = 1'b1;
                        rphase    = 3;
                    end
                end
                default: begin
                    resp_ack  = 1'b0;
                    resp_done = 1'b0;
                    rphase    = 0;
                end
            endcase
        end
    end

    // Reference model: advances one clock using only the bench's inputs.
    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_acked = 0; m_last_rd = 1; m_wr_pend = 0; m_rd_pend = 0;
            m_fwd = 0; m_frd = 0; m_type = 0; m_addr = 0; m_len = 0; m_wr_addr = 0; m_rd_addr = 0;
        end else begin
            m_fwd = 0;
            m_frd = 0;
            m_done_now = m_busy && cmd_done && (m_acked || cmd_ack);
            if (m_done_now && m_type == 1) begin
                m_nxt     = m_wr_addr + longint'(wr_length);
                m_fwd     = (m_nxt >= longint'(wr_max));
                m_wr_addr = (m_fwd || wr_load || m_wr_pend) ? longint'(wr_base) : m_nxt;
                m_wr_pend = 0;
            end else if (wr_load) begin
                if (m_busy && m_type == 1 && (m_acked || cmd_ack)) m_wr_pend = 1;
                else begin
                    m_wr_addr = wr_base;
                    if (m_busy && m_type == 1) m_addr = wr_base;
                end
            end
            if (m_done_now && m_type == 2) begin
                m_nxt     = m_rd_addr + longint'(rd_length);
                m_frd     = (m_nxt >= longint'(rd_max));
                m_rd_addr = (m_frd || rd_load || m_rd_pend) ? longint'(rd_base) : m_nxt;
                m_rd_pend = 0;
            end else if (rd_load) begin
                if (m_busy && m_type == 2 && (m_acked || cmd_ack)) m_rd_pend = 1;
                else begin
                    m_rd_addr = rd_base;
                    if (m_busy && m_type == 2) m_addr = rd_base;
                end
            end
            if (!m_busy) begin
                m_acked = 0;
                if (sdram_init_done) begin
                    m_wr_ok = (wr_fifo_used >= wr_length);
                    m_rd_ok = rd_enable && (int'(rd_fifo_used) <= RD_MARK_TB);
                    if (ref_req) begin
                        m_busy = 1; m_type = 3; m_addr = 0; m_len = 0;
                    end else if (m_wr_ok && (!m_rd_ok || m_last_rd)) begin
                        m_busy = 1; m_type = 1; m_addr = m_wr_addr; m_len = wr_length; m_last_rd = 0;
                    end else if (m_rd_ok) begin
                        m_busy = 1; m_type = 2; m_addr = m_rd_addr; m_len = rd_length; m_last_rd = 1;
                    end
                end
            end else if (m_done_now) begin
                m_busy = 0; m_acked = 0; m_type = 0; m_addr = 0; m_len = 0;
            end else if (cmd_ack) begin
                m_acked = 1;
            end
        end
    end

    // Compare process and transaction monitor, one time step after each rising edge.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            checkOutput("cmd_req", cmd_req, longint'(m_busy && !m_acked));
            checkOutput("busy", busy, m_busy);
            checkOutput("cmd_type", cmd_type, m_type);
            checkOutput("cmd_addr", cmd_addr, m_addr);
            checkOutput("cmd_len", cmd_len, m_len);
            checkOutput("frame_write_done", frame_write_done, m_fwd);
            checkOutput("frame_read_done", frame_read_done, m_frd);
        end
        if (cmd_req && !prev_req) begin
            q_type.push_back(longint'(cmd_type));
            q_addr.push_back(longint'(cmd_addr));
            issue_count++;
        end
        prev_req = cmd_req;
        if (frame_write_done) fwd_count++;
        if (frame_read_done) frd_count++;
    end

    initial begin
        compared = 0; mismatched = 0; chk_en = 0;
        resp_en = 0; man_ack = 0; man_done = 0; done_dly = 4;
        rphase = 0; rcnt = 0; resp_ack = 0; resp_done = 0;
        wr_load = 0; rd_load = 0; rst = 1;
        wr_base = 22'd0; wr_max = 22'd1024; rd_base = 22'd0; rd_max = 22'h200000;
        applyStimulus(0, 0, 1000, 0, 256, 256, 0);

        $display("[TB] refresh on an idle bus");
        applyStimulus(1, 0, 1000, 0, 256, 256, 1);
        do_reset();
        checkOutput("ref_c1_req", cmd_req, 0);
        tick();
        checkOutput("ref_c2_req", cmd_req, 1);
        checkOutput("ref_c2_type", cmd_type, 3);
        tick();
        tick();
        man_ack = 1;
        tick();
        man_ack = 0;
        ref_req = 0;
        checkOutput("ref_c5_req", cmd_req, 0);
        checkOutput("ref_c5_busy", busy, 1);
        tick();
        tick();
        tick();
        man_done = 1;
        tick();
        man_done = 0;
        checkOutput("ref_c9_busy", busy, 0);
        checkOutput("ref_c9_type", cmd_type, 0);

        $display("[TB] write frame wrap");
        applyStimulus(1, 300, 1000, 0, 256, 256, 0);
        wr_base = 22'd0; wr_max = 22'd1024;
        do_reset();
        done_dly = 4;
        resp_en  = 1;
        wait_issues("wf_issues", 5, 200);
        checkOutput("wf_addr0", get_addr(0), 0);
        checkOutput("wf_addr1", get_addr(1), 256);
        checkOutput("wf_addr2", get_addr(2), 512);
        checkOutput("wf_addr3", get_addr(3), 768);
        checkOutput("wf_addr4", get_addr(4), 0);
        checkOutput("wf_frame_pulses", fwd_count, 1);

        $display("[TB] write/read round-robin with ack and done together");
        applyStimulus(1, 300, 100, 1, 256, 128, 0);
        do_reset();
        done_dly = 0;
        resp_en  = 1;
        wait_issues("rr_issues", 4, 200);
        checkOutput("rr_type0", get_type(0), 1);
        checkOutput("rr_type1", get_type(1), 2);
        checkOutput("rr_type2", get_type(2), 1);
        checkOutput("rr_type3", get_type(3), 2);
        checkOutput("rr_addr3", get_addr(3), 128);

        $display("[TB] refresh pre-empts the round-robin");
        applyStimulus(1, 300, 100, 1, 256, 128, 0);
        do_reset();
        done_dly = 4;
        resp_en  = 1;
        wait_issues("pre_first", 1, 50);
        wait_accepted("pre_wait_done");
        ref_req = 1;
        wait_issues("pre_second", 2, 50);
        ref_req = 0;
        wait_issues("pre_third", 3, 50);
        checkOutput("pre_type0", get_type(0), 1);
        checkOutput("pre_type1", get_type(1), 3);
        checkOutput("pre_type2", get_type(2), 2);

        $display("[TB] read load during an accepted burst");
        applyStimulus(1, 0, 100, 1, 256, 256, 0);
        rd_base = 22'd0; rd_max = 22'h200000;
        do_reset();
        done_dly = 4;
        resp_en  = 1;
        wait_issues("ld_three", 3, 100);
        wait_accepted("ld_wait_done");
        checkOutput("ld_addr2", get_addr(2), 512);
        rd_load = 1;
        rd_base = 22'h100000;
        tick();
        rd_load = 0;
        wait_issues("ld_four", 4, 50);
        checkOutput("ld_addr3", get_addr(3), 64'h100000);
        checkOutput("ld_type3", get_type(3), 2);
        checkOutput("ld_frame_pulses", frd_count, 0);

        $display("[TB] init gating and reset mid-command");
        applyStimulus(0, 300, 100, 1, 256, 256, 1);
        do_reset();
        for (int i = 0; i < 20; i++) tick();
        checkOutput("gate_issues", issue_count, 0);
        checkOutput("gate_busy", busy, 0);
        sdram_init_done = 1;
        wait_issues("rst_issue", 1, 10);
        checkOutput("rst_type", get_type(0), 3);
        man_ack = 1;
        tick();
        man_ack = 0;
        checkOutput("rst_in_wait", busy && !cmd_req, 1);
        rst = 1;
        applyStimulus(1, 0, 1000, 0, 256, 256, 0);
        tick();
        rst = 0;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_type_clr", cmd_type, 0);
        man_done = 1;
        man_ack  = 1;
        tick();
        man_done = 0;
        man_ack  = 0;
        tick();
        checkOutput("rst_late_busy", busy, 0);
        checkOutput("rst_late_req", cmd_req, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
